sync_gen: RTL



---
 rtl/sync_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sync_gen.sv
// -----------------------------------------------------------------------------
// sync_gen
// Raster timing generator. Walks a programmable horizontal/vertical raster
// (active, front porch, sync, back porch) one position per pixel clock and
// emits the {frame sync, line sync, data enable} bundle consumed downstream
// as Synci[26:24]. A frame that has started always runs to its last position;
// the run enable is only looked at there (or while idle).
//
// Ports:
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable (level)
//   Synco      out  [26] VS, [25] HS, [24] DE, all active-high
//   h_cnt      out  horizontal position of the current Synco
//   v_cnt      out  vertical position of the current Synco
//   frame_end  out  one-cycle pulse at the last raster position
//   frame_cnt  out  completed frames, wraps mod 2^16
//   busy       out  high while running
// -----------------------------------------------------------------------------
module sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [26:24] Synco,
  output logic [15:0]  h_cnt,
  output logic [15:0]  v_cnt,
  output logic         frame_end,
  output logic [15:0]  frame_cnt,
  output logic         busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
  localparam logic [15:0] H_HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
  localparam logic [15:0] V_VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_h;
  logic [15:0] r_v;
  logic [2:0]  r_sync;
  logic        r_frameEnd;
  logic [15:0] r_frameCnt;

  logic [0:0]  w_nextState;
  logic [15:0] w_hNext;
  logic [15:0] w_vNext;
  logic        w_atLast;
  logic        w_nextRun;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic        w_feNext;

  assign w_atLast = (r_state == ST_RUN) && (r_h == H_LAST) && (r_v == V_LAST);

  // Next raster position. The enable only matters while idle or at the very
  // last position, so dropping it mid-frame never cuts a frame short.
  always_comb begin
    w_nextState = r_state;
    w_hNext     = r_h;
    w_vNext     = r_v;
    case (r_state)
      ST_IDLE: begin
        w_hNext = 16'd0;
        w_vNext = 16'd0;
        if (en) begin
          w_nextState = ST_RUN;
        end
      end
      default: begin
        if (w_atLast) begin
          w_hNext = 16'd0;
          w_vNext = 16'd0;
          if (!en) begin
            w_nextState = ST_IDLE;
          end
        end else if (r_h == H_LAST) begin
          w_hNext = 16'd0;
          w_vNext = r_v + 16'd1;
        end else begin
          w_hNext = r_h + 16'd1;
        end
      end
    endcase
  end

  // Decode is done on the next position so that sync, position, frame_end
  // and busy all leave the same flop edge together.
  assign w_nextRun = (w_nextState == ST_RUN);
  assign w_vs = w_nextRun && (w_vNext >= V_VS_START) && (w_vNext < V_VS_END);
  assign w_hs = w_nextRun && (w_hNext >= H_HS_START) && (w_hNext < H_HS_END);
  // VS rows are never active rows, but DE is masked by VS anyway: the
  // consumer would lose its pixel-index reset if both were ever high.
  assign w_de = w_nextRun && (w_hNext < H_ACT_END) && (w_vNext < V_ACT_END) && !w_vs;
  assign w_feNext = w_nextRun && (w_hNext == H_LAST) && (w_vNext == V_LAST);

  // State, position and decoded outputs. The frame counter steps on the edge
  // that leaves the last position, whether the raster continues or stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_h        <= 16'd0;
      r_v        <= 16'd0;
      r_sync     <= 3'b000;
      r_frameEnd <= 1'b0;
      r_frameCnt <= 16'd0;
    end else begin
      r_state    <= w_nextState;
      r_h        <= w_hNext;
      r_v        <= w_vNext;
      r_sync     <= {w_vs, w_hs, w_de};
      r_frameEnd <= w_feNext;
      if (w_atLast) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
    end
  end

  assign Synco     = r_sync;
  assign h_cnt     = r_h;
  assign v_cnt     = r_v;
  assign frame_end = r_frameEnd;
  assign frame_cnt = r_frameCnt;
  assign busy      = (r_state == ST_RUN);

endmodule
